// File: rtl/divconv_pkg.sv
// divconv_pkg: shared types and widths for the divconv request sequencer.
//   SIG_W  - operand significand width (1.52 format)
//   Q_W    - candidate quotient width
//   REM_W  - remainder register width (MSB is the sign)
//   divconv_issue_state_t - sequencer state encoding
package divconv_pkg;

  localparam int unsigned SIG_W = 53;
  localparam int unsigned Q_W   = 64;
  localparam int unsigned REM_W = 128;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StCapture,
    StHold
  } divconv_issue_state_t;

endpackage

// File: rtl/divconv_qsel.sv
// divconv_qsel: combinational final-quotient selection.
// Ports:
//   p_i            - precision (1 = double set q0/qm0/qp0, 0 = single set q1/qm1/qp1)
//   regr_out_i     - remainder register, MSB is the sign
//   q*_i           - candidate quotients
//   q_o            - selected quotient
//   exact_o        - remainder was exactly zero
module divconv_qsel
  import divconv_pkg::*;
(
  input  logic             p_i,
  input  logic [REM_W-1:0] regr_out_i,
  input  logic [Q_W-1:0]   q0_i,
  input  logic [Q_W-1:0]   qm0_i,
  input  logic [Q_W-1:0]   qp0_i,
  input  logic [Q_W-1:0]   q1_i,
  input  logic [Q_W-1:0]   qm1_i,
  input  logic [Q_W-1:0]   qp1_i,
  output logic [Q_W-1:0]   q_o,
  output logic             exact_o
);

  logic [Q_W-1:0] q_set;
  logic [Q_W-1:0] qm_set;
  logic           rem_zero;
  logic           rem_neg;

  // qp candidates are consumed by the rounding stage, not here.
  logic unused_qp;
  assign unused_qp = ^{qp0_i, qp1_i};

  always_comb begin
    q_set    = p_i ? q0_i : q1_i;
    qm_set   = p_i ? qm0_i : qm1_i;
    rem_zero = (regr_out_i == '0);
    // Negative remainder means the quotient estimate overshot by one ulp.
    rem_neg  = regr_out_i[REM_W-1];
    exact_o  = rem_zero;
    q_o      = rem_neg ? qm_set : q_set;
  end

endmodule

// File: rtl/divconv_issue.sv
// divconv_issue: request-side sequencer for the Goldschmidt divide/sqrt datapath.
// Accepts one operand request (valid/ready), drives registered operands plus a
// START_CYCLES-long start pulse into the controller, waits for done, selects the
// final quotient from the remainder sign and holds it until res_ready.
// Ports:
//   clk, reset                        - clock, async active-high reset
//   req_valid/req_ready, req_*        - request handshake and operands
//   n, d, P, op_type, exp_odd         - registered operands/controls to the datapath
//   start, error / done               - controller handshake
//   q0/qm0/qp0, q1/qm1/qp1, regr_out  - datapath results
//   res_valid/res_ready, res_q, res_exact, res_timeout - result handshake
// Optional feature: define DIVCONV_TIMEOUT_EN to enable the WAIT watchdog
// (TIMEOUT cycles); otherwise error and res_timeout stay 0.
module divconv_issue
  import divconv_pkg::*;
#(
  parameter int unsigned START_CYCLES = 4,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [SIG_W-1:0] req_n,
  input  logic [SIG_W-1:0] req_d,
  input  logic             req_p,
  input  logic             req_op,
  input  logic             req_exp_odd,
  output logic [SIG_W-1:0] n,
  output logic [SIG_W-1:0] d,
  output logic             P,
  output logic             op_type,
  output logic             exp_odd,
  output logic             start,
  output logic             error,
  input  logic             done,
  input  logic [Q_W-1:0]   q0,
  input  logic [Q_W-1:0]   qm0,
  input  logic [Q_W-1:0]   qp0,
  input  logic [Q_W-1:0]   q1,
  input  logic [Q_W-1:0]   qm1,
  input  logic [Q_W-1:0]   qp1,
  input  logic [REM_W-1:0] regr_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [Q_W-1:0]   res_q,
  output logic             res_exact,
  output logic             res_timeout
);

  localparam int unsigned StartCntW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

  divconv_issue_state_t state_q, state_d;
  logic [StartCntW-1:0] scnt_q, scnt_d;
  logic [SIG_W-1:0]     n_q, n_d, d_q, d_d;
  logic                 p_q, p_d, op_q, op_d, odd_q, odd_d;
  logic                 req_ready_q, req_ready_d;
  logic                 start_q, start_d;
  logic                 error_q, error_d;
  logic                 res_valid_q, res_valid_d;
  logic [Q_W-1:0]       res_q_q, res_q_d;
  logic                 res_exact_q, res_exact_d;
  logic                 res_timeout_q, res_timeout_d;

  logic [Q_W-1:0]       sel_q;
  logic                 sel_exact;

`ifdef DIVCONV_TIMEOUT_EN
  localparam int unsigned TimeoutCntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TimeoutCntW-1:0] wcnt_q, wcnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  divconv_qsel u_qsel (
    .p_i        (p_q),
    .regr_out_i (regr_out),
    .q0_i       (q0),
    .qm0_i      (qm0),
    .qp0_i      (qp0),
    .q1_i       (q1),
    .qm1_i      (qm1),
    .qp1_i      (qp1),
    .q_o        (sel_q),
    .exact_o    (sel_exact)
  );

  always_comb begin
    state_d       = state_q;
    scnt_d        = scnt_q;
    n_d           = n_q;
    d_d           = d_q;
    p_d           = p_q;
    op_d          = op_q;
    odd_d         = odd_q;
    req_ready_d   = req_ready_q;
    start_d       = 1'b0;
    error_d       = 1'b0;
    res_valid_d   = res_valid_q;
    res_q_d       = res_q_q;
    res_exact_d   = res_exact_q;
    res_timeout_d = res_timeout_q;
`ifdef DIVCONV_TIMEOUT_EN
    wcnt_d        = wcnt_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          n_d         = req_n;
          d_d         = req_d;
          p_d         = req_p;
          op_d        = req_op;
          odd_d       = req_exp_odd;
          req_ready_d = 1'b0;
          start_d     = 1'b1;
          scnt_d      = StartCntW'(START_CYCLES - 1);
          state_d     = StIssue;
`ifdef DIVCONV_TIMEOUT_EN
          wcnt_d      = '0;
`endif
        end
      end
      StIssue: begin
        // done from a previous/foreign operation is ignored while issuing.
        if (scnt_q == '0) begin
          state_d = StWait;
        end else begin
          scnt_d  = scnt_q - StartCntW'(1);
          start_d = 1'b1;
        end
      end
      StWait: begin
        if (done) begin
          state_d = StCapture;
`ifdef DIVCONV_TIMEOUT_EN
        end else if (wcnt_q == TimeoutCntW'(TIMEOUT - 1)) begin
          error_d       = 1'b1;
          res_valid_d   = 1'b1;
          res_q_d       = '0;
          res_exact_d   = 1'b0;
          res_timeout_d = 1'b1;
          state_d       = StHold;
        end else begin
          wcnt_d = wcnt_q + TimeoutCntW'(1);
`endif
        end
      end
      StCapture: begin
        res_q_d       = sel_q;
        res_exact_d   = sel_exact;
        res_timeout_d = 1'b0;
        res_valid_d   = 1'b1;
        state_d       = StHold;
      end
      StHold: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d     = StIdle;
        req_ready_d = 1'b1;
        res_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      scnt_q        <= '0;
      n_q           <= '0;
      d_q           <= '0;
      p_q           <= 1'b0;
      op_q          <= 1'b0;
      odd_q         <= 1'b0;
      req_ready_q   <= 1'b1;
      start_q       <= 1'b0;
      error_q       <= 1'b0;
      res_valid_q   <= 1'b0;
      res_q_q       <= '0;
      res_exact_q   <= 1'b0;
      res_timeout_q <= 1'b0;
`ifdef DIVCONV_TIMEOUT_EN
      wcnt_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      scnt_q        <= scnt_d;
      n_q           <= n_d;
      d_q           <= d_d;
      p_q           <= p_d;
      op_q          <= op_d;
      odd_q         <= odd_d;
      req_ready_q   <= req_ready_d;
      start_q       <= start_d;
      error_q       <= error_d;
      res_valid_q   <= res_valid_d;
      res_q_q       <= res_q_d;
      res_exact_q   <= res_exact_d;
      res_timeout_q <= res_timeout_d;
`ifdef DIVCONV_TIMEOUT_EN
      wcnt_q        <= wcnt_d;
`endif
    end
  end

  assign req_ready   = req_ready_q;
  assign n           = n_q;
  assign d           = d_q;
  assign P           = p_q;
  assign op_type     = op_q;
  assign exp_odd     = odd_q;
  assign start       = start_q;
  assign error       = error_q;
  assign res_valid   = res_valid_q;
  assign res_q       = res_q_q;
  assign res_exact   = res_exact_q;
  assign res_timeout = res_timeout_q;

endmodule

// File: tb/tb_divconv_issue.sv
module tb_divconv_issue;
  import divconv_pkg::*;

  localparam int unsigned StartCycles = 4;
  localparam int unsigned Timeout     = 64;

  localparam logic [63:0] CQ0  = 64'h3FF4_0000_0000_0001;
  localparam logic [63:0] CQM0 = 64'h3FF4_0000_0000_0000;
  localparam logic [63:0] CQP0 = 64'h3FF4_0000_0000_0002;
  localparam logic [63:0] CQ1  = 64'h0000_0000_3FA0_0011;
  localparam logic [63:0] CQM1 = 64'h0000_0000_3FA0_0010;
  localparam logic [63:0] CQP1 = 64'h0000_0000_3FA0_0012;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid, req_ready;
  logic [SIG_W-1:0] req_n, req_d;
  logic             req_p, req_op, req_exp_odd;
  logic [SIG_W-1:0] n, d;
  logic             P, op_type, exp_odd, start, error, done;
  logic [Q_W-1:0]   q0, qm0, qp0, q1, qm1, qp1;
  logic [REM_W-1:0] regr_out;
  logic             res_valid, res_ready, res_exact, res_timeout;
  logic [Q_W-1:0]   res_q;

  always #5 clk = ~clk;

  divconv_issue #(
    .START_CYCLES (StartCycles),
    .TIMEOUT      (Timeout)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_n       (req_n),
    .req_d       (req_d),
    .req_p       (req_p),
    .req_op      (req_op),
    .req_exp_odd (req_exp_odd),
    .n           (n),
    .d           (d),
    .P           (P),
    .op_type     (op_type),
    .exp_odd     (exp_odd),
    .start       (start),
    .error       (error),
    .done        (done),
    .q0          (q0),
    .qm0         (qm0),
    .qp0         (qp0),
    .q1          (q1),
    .qm1         (qm1),
    .qp1         (qp1),
    .regr_out    (regr_out),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_q       (res_q),
    .res_exact   (res_exact),
    .res_timeout (res_timeout)
  );

  typedef struct {
    logic [52:0]  n;
    logic [52:0]  d;
    logic         p;
    logic         op;
    logic         odd;
    logic [127:0] regr;
    int           delay;
    logic [63:0]  exp_q;
    logic         exp_exact;
  } vec_t;

  typedef struct {
    logic [63:0] q;
    logic        exact;
    logic        tmo;
  } exp_t;

  vec_t vecs[7];
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  logic [108:0] ops_exp;
  bit           ops_track = 1'b0;
  int           ops_bad = 0;
  int           err_pulses = 0;

  always @(negedge clk) begin
    if (ops_track && ({n, d, P, op_type, exp_odd} !== ops_exp)) ops_bad++;
    if (error === 1'b1) err_pulses++;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input vec_t v, input exp_t e);
    int t = 0;
    while (req_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("req_ready_before_accept", req_ready, 1);
    req_n       = v.n;
    req_d       = v.d;
    req_p       = v.p;
    req_op      = v.op;
    req_exp_odd = v.odd;
    req_valid   = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    check("req_ready_after_accept", req_ready, 0);
    check("operands_latched", {n, d, P, op_type, exp_odd}, {v.n, v.d, v.p, v.op, v.odd});
    ops_exp   = {v.n, v.d, v.p, v.op, v.odd};
    ops_bad   = 0;
    ops_track = 1'b1;
  endtask

  // Counts start-high cycles from the first ISSUE cycle; optionally pulses done mid-ISSUE.
  task automatic count_start(input bit pulse_done);
    int cnt = 0;
    int t = 0;
    while (start === 1'b1 && t < 50) begin
      cnt++;
      if (pulse_done && cnt == 2) done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      t++;
    end
    check("start_cycles", cnt, StartCycles);
  endtask

  task automatic consume(input int hold);
    logic [63:0] snap;
    exp_t        e;
    int          bad = 0;
    snap = res_q;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_n     = 53'h1;
      @(negedge clk);
      if (res_valid !== 1'b1 || res_q !== snap || req_ready !== 1'b0 || start !== 1'b0) bad++;
    end
    req_valid = 1'b0;
    if (hold > 0) check("hold_stable", bad, 0);
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 0, 1);
    end else begin
      e = sb.pop_front();
      check("res_q", res_q, e.q);
      check("res_exact", res_exact, e.exact);
      check("res_timeout", res_timeout, e.tmo);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("res_valid_drop", res_valid, 0);
    check("req_ready_return", req_ready, 1);
    check("operands_stable", ops_bad, 0);
    ops_track = 1'b0;
  endtask

  task automatic run_op(input vec_t v, input int hold, input bit pulse_done);
    exp_t e;
    e.q     = v.exp_q;
    e.exact = v.exp_exact;
    e.tmo   = 1'b0;
    drive_req(v, e);
    count_start(pulse_done);
    repeat (v.delay) @(negedge clk);
    check("no_result_before_done", res_valid, 0);
    regr_out = v.regr;
    done     = 1'b1;
    @(negedge clk);
    done = 1'b0;
    check("capture_cycle_not_valid", res_valid, 0);
    @(negedge clk);
    check("res_valid_rise", res_valid, 1);
    consume(hold);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_n       = '0;
    req_d       = '0;
    req_p       = 1'b0;
    req_op      = 1'b0;
    req_exp_odd = 1'b0;
    done        = 1'b0;
    res_ready   = 1'b0;
    regr_out    = '0;
    q0 = CQ0; qm0 = CQM0; qp0 = CQP0;
    q1 = CQ1; qm1 = CQM1; qp1 = CQP1;

    //        n                d                p     op    odd   regr                                        dly exp_q exact
    vecs[0] = '{53'h13F3B648000000, 53'h1A666668000000, 1'b1, 1'b0, 1'b0,
                {1'b1, 127'h1}, 20, CQM0, 1'b0};
    vecs[1] = '{53'h10000000000000, 53'h18000000000000, 1'b0, 1'b0, 1'b0,
                128'h0, 3, CQ1, 1'b1};
    vecs[2] = '{53'h1C000000000000, 53'h10000000000000, 1'b1, 1'b0, 1'b0,
                128'h0, 0, CQ0, 1'b1};
    vecs[3] = '{53'h15555555555555, 53'h11111111111111, 1'b0, 1'b0, 1'b0,
                128'h1, 1, CQ1, 1'b0};
    vecs[4] = '{53'h1FFFFFFFFFFFFF, 53'h10000000000001, 1'b0, 1'b0, 1'b0,
                {1'b1, 127'h0}, 7, CQM1, 1'b0};
    vecs[5] = '{53'h123456789ABCDE, 53'h1EDCBA98765432, 1'b1, 1'b0, 1'b0,
                {1'b0, {127{1'b1}}}, 2, CQ0, 1'b0};
    vecs[6] = '{53'h18000000000000, 53'h00000000000000, 1'b1, 1'b1, 1'b1,
                {1'b1, 127'h5}, 5, CQM0, 1'b0};

    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_start_error", {start, error}, 0);
    check("rst_res_flags", {res_valid, res_exact, res_timeout}, 0);
    check("rst_operands", {n, d, P, op_type, exp_odd}, 0);
    check("rst_res_q", res_q, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_op(vecs[i], (i == 0) ? 10 : 0, 1'b0);

    // done pulsed during ISSUE must be ignored; exactly one result results.
    run_op(vecs[3], 0, 1'b1);
    repeat (5) @(negedge clk);
    check("single_result_valid", res_valid, 0);
    check("single_result_sb", sb.size(), 0);

    // Reset during WAIT discards the operation.
    begin
      exp_t e;
      e.q = vecs[1].exp_q; e.exact = vecs[1].exp_exact; e.tmo = 1'b0;
      drive_req(vecs[1], e);
      count_start(1'b0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("reset_mid_start", start, 0);
      check("reset_mid_res_valid", res_valid, 0);
      check("reset_mid_req_ready", req_ready, 1);
      reset = 1'b0;
      void'(sb.pop_back());
      ops_track = 1'b0;
      @(negedge clk);
      run_op(vecs[4], 2, 1'b0);
    end

`ifdef DIVCONV_TIMEOUT_EN
    begin
      exp_t e;
      int   cnt = 0;
      e.q = 64'h0; e.exact = 1'b0; e.tmo = 1'b1;
      drive_req(vecs[0], e);
      count_start(1'b0);
      while (error !== 1'b1 && cnt < 200) begin
        @(negedge clk);
        cnt++;
      end
      check("timeout_cycles", cnt, Timeout);
      check("timeout_res_valid", res_valid, 1);
      @(negedge clk);
      check("timeout_error_one_cycle", error, 0);
      consume(0);
    end
    check("error_pulse_count", err_pulses, 1);
`else
    check("error_pulse_count", err_pulses, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
